timer_ctrl: RTL and testbench

Sequencing controller for the MM:SS countdown timer. It owns the four BCD digit registers and the run/pause/set/expired state machine. It consumes single-cycle button pulses from the debouncers and a rate tick from the variable clock divider. Its digit and blink outputs drive the four blinking seven-segment decoders directly, so no binary-to-BCD division is needed in the datapath.

---
 rtl/timer_ctrl.sv | 167 ++++++++++++++++
 tb/tb_timer_ctrl.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/timer_ctrl.sv
// timer_ctrl: MM:SS countdown sequencer. Owns the four BCD digit registers
// and the PAUSE/RUN/SET_MIN/SET_SEC/EXPIRED state machine; drives digits,
// blink enables and status flags straight to the seven-segment decoders.
// Optional feature macro: TIMER_CTRL_AUTORELOAD_EN (EXPIRED auto-reloads
// INIT after EXPIRE_TICKS ticks and resumes counting).
module timer_ctrl #(
  parameter int INIT_MIN     = 1,
  parameter int INIT_SEC     = 0,
  parameter int EXPIRE_TICKS = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       pause_p,
  input  logic       mode_p,
  input  logic       inc_p,
  output logic [3:0] m1,
  output logic [3:0] m0,
  output logic [3:0] s1,
  output logic [3:0] s0,
  output logic [3:0] blink,
  output logic       running,
  output logic       expired
);

  typedef enum logic [2:0] {PAUSE, RUN, SET_MIN, SET_SEC, EXPIRED} state_t;
  state_t state;

  localparam logic [3:0] IM1 = 4'(INIT_MIN / 10);
  localparam logic [3:0] IM0 = 4'(INIT_MIN % 10);
  localparam logic [3:0] IS1 = 4'(INIT_SEC / 10);
  localparam logic [3:0] IS0 = 4'(INIT_SEC % 10);

  // {blink, running, expired} as a pure function of the state being entered,
  // so the flags are registered on the same edge as the state itself.
  function automatic logic [5:0] flags(state_t s);
    case (s)
      RUN:     flags = 6'b0000_10;
      SET_MIN: flags = 6'b1100_00;
      SET_SEC: flags = 6'b0011_00;
      EXPIRED: flags = 6'b1111_01;
      default: flags = 6'b0000_00;
    endcase
  endfunction

  logic [3:0] dm1, dm0, ds1, ds0;   // digits after one BCD decrement
  logic [3:0] im1, im0, is1, is0;   // minutes / seconds after BCD increment
  logic       is_zero, dec_zero;

  // BCD decrement with borrow chain s0 -> s1 -> m0 -> m1
  always_comb begin
    dm1 = m1; dm0 = m0; ds1 = s1; ds0 = s0;
    if (s0 != 4'd0) ds0 = s0 - 4'd1;
    else begin
      ds0 = 4'd9;
      if (s1 != 4'd0) ds1 = s1 - 4'd1;
      else begin
        ds1 = 4'd5;
        if (m0 != 4'd0) dm0 = m0 - 4'd1;
        else begin
          dm0 = 4'd9;
          dm1 = m1 - 4'd1;
        end
      end
    end
    is_zero  = (m1 == 4'd0) && (m0 == 4'd0) && (s1 == 4'd0) && (s0 == 4'd0);
    dec_zero = (m1 == 4'd0) && (m0 == 4'd0) && (s1 == 4'd0) && (s0 == 4'd1);
  end

  // BCD increment of minutes and seconds, 59 wraps to 00
  always_comb begin
    im1 = m1; im0 = m0 + 4'd1;
    if (m0 == 4'd9) begin
      im0 = 4'd0;
      im1 = (m1 == 4'd5) ? 4'd0 : m1 + 4'd1;
    end
    is1 = s1; is0 = s0 + 4'd1;
    if (s0 == 4'd9) begin
      is0 = 4'd0;
      is1 = (s1 == 4'd5) ? 4'd0 : s1 + 4'd1;
    end
  end

`ifdef TIMER_CTRL_AUTORELOAD_EN
  localparam logic [3:0] EXP_LAST  = 4'(EXPIRE_TICKS - 1);
  localparam logic       INIT_ZERO = (INIT_MIN == 0) && (INIT_SEC == 0);
  logic [3:0] exp_cnt;
`endif

  // State machine: each state tests only the events it honours, in priority
  // order mode > pause > inc > tick, so lower events are simply dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= PAUSE;
      {m1, m0, s1, s0} <= {IM1, IM0, IS1, IS0};
      {blink, running, expired} <= flags(PAUSE);
`ifdef TIMER_CTRL_AUTORELOAD_EN
      exp_cnt <= 4'd0;
`endif
    end else begin
      case (state)
        PAUSE: begin
          if (mode_p) begin
            state <= SET_MIN; {blink, running, expired} <= flags(SET_MIN);
          end else if (pause_p && !is_zero) begin
            state <= RUN; {blink, running, expired} <= flags(RUN);
          end
        end
        RUN: begin
          if (mode_p) begin
            state <= SET_MIN; {blink, running, expired} <= flags(SET_MIN);
          end else if (pause_p) begin
            state <= PAUSE; {blink, running, expired} <= flags(PAUSE);
          end else if (tick && !is_zero) begin
            {m1, m0, s1, s0} <= {dm1, dm0, ds1, ds0};
            if (dec_zero) begin
              state <= EXPIRED; {blink, running, expired} <= flags(EXPIRED);
            end
          end
        end
        SET_MIN: begin
          if (mode_p) begin
            state <= SET_SEC; {blink, running, expired} <= flags(SET_SEC);
          end else if (inc_p) begin
            {m1, m0} <= {im1, im0};
          end
        end
        SET_SEC: begin
          if (mode_p) begin
            state <= PAUSE; {blink, running, expired} <= flags(PAUSE);
          end else if (inc_p) begin
            {s1, s0} <= {is1, is0};
          end
        end
        EXPIRED: begin
          if (mode_p) begin
            state <= SET_MIN; {blink, running, expired} <= flags(SET_MIN);
`ifdef TIMER_CTRL_AUTORELOAD_EN
            exp_cnt <= 4'd0;
`endif
          end else if (pause_p) begin
            state <= PAUSE; {blink, running, expired} <= flags(PAUSE);
            {m1, m0, s1, s0} <= {IM1, IM0, IS1, IS0};
`ifdef TIMER_CTRL_AUTORELOAD_EN
            exp_cnt <= 4'd0;
          end else if (tick) begin
            if (exp_cnt == EXP_LAST) begin
              exp_cnt <= 4'd0;
              {m1, m0, s1, s0} <= {IM1, IM0, IS1, IS0};
              // A 00:00 reload would expire at once, so stay put instead.
              if (!INIT_ZERO) begin
                state <= RUN; {blink, running, expired} <= flags(RUN);
              end
            end else begin
              exp_cnt <= exp_cnt + 4'd1;
            end
`endif
          end
        end
        default: begin
          state <= PAUSE; {blink, running, expired} <= flags(PAUSE);
        end
      endcase
    end
  end

endmodule

// File: tb/tb_timer_ctrl.sv
// Directed bench for timer_ctrl with default parameters (INIT 01:00).
// Flag vectors are {blink, running, expired}.
module tb_timer_ctrl;
  logic clk = 1'b0, rst = 1'b1;
  logic tick = 1'b0, pause_p = 1'b0, mode_p = 1'b0, inc_p = 1'b0;
  logic [3:0] m1, m0, s1, s0, blink;
  logic running, expired;
  int passes = 0, total = 0;

  localparam logic [5:0] F_PAUSE = 6'b0000_00;
  localparam logic [5:0] F_RUN   = 6'b0000_10;
  localparam logic [5:0] F_SMIN  = 6'b1100_00;
  localparam logic [5:0] F_SSEC  = 6'b0011_00;
  localparam logic [5:0] F_EXP   = 6'b1111_01;

  timer_ctrl dut (
    .clk(clk), .rst(rst), .tick(tick), .pause_p(pause_p), .mode_p(mode_p),
    .inc_p(inc_p), .m1(m1), .m0(m0), .s1(s1), .s0(s0), .blink(blink),
    .running(running), .expired(expired)
  );

  always #5 clk = ~clk;

  wire [15:0] dig = {m1, m0, s1, s0};
  wire [5:0]  flg = {blink, running, expired};

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: got %h want %h", tag, obs, exp);
  endtask

  // Present one cycle of pulses, clocked on the next edge, sampled 1ns after.
  task automatic step(input logic t, input logic p, input logic m, input logic i);
    tick = t; pause_p = p; mode_p = m; inc_p = i;
    @(posedge clk); #1;
    tick = 1'b0; pause_p = 1'b0; mode_p = 1'b0; inc_p = 1'b0;
  endtask

  task automatic ticks(input int n);  repeat (n) step(1'b1, 1'b0, 1'b0, 1'b0); endtask
  task automatic incs(input int n);   repeat (n) step(1'b0, 1'b0, 1'b0, 1'b1); endtask
  task automatic pause1();            step(1'b0, 1'b1, 1'b0, 1'b0); endtask
  task automatic mode1();             step(1'b0, 1'b0, 1'b1, 1'b0); endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_digits", dig, 16'h0100);
    chk("rst_flags", {10'd0, flg}, {10'd0, F_PAUSE});
    rst = 1'b0;
    ticks(3);
    chk("pause_ignores_tick", dig, 16'h0100);

    // Count down from 01:00 to expiry
    pause1();
    chk("run_flags", {10'd0, flg}, {10'd0, F_RUN});
    ticks(1);
    chk("borrow_minute", dig, 16'h0059);
    ticks(58);
    chk("at_0001", dig, 16'h0001);
    chk("still_run", {10'd0, flg}, {10'd0, F_RUN});
    ticks(1);
    chk("to_0000", dig, 16'h0000);
    chk("expired_flags", {10'd0, flg}, {10'd0, F_EXP});
    ticks(1);
    chk("exp_hold", dig, 16'h0000);

    // Set 10:00 and decrement across both borrows
    mode1();
    chk("exp_mode", {10'd0, flg}, {10'd0, F_SMIN});
    incs(10);
    chk("set_10", dig, 16'h1000);
    mode1(); mode1(); pause1();
    ticks(1);
    chk("1000_dec", dig, 16'h0959);

    // Minute wrap over 61 incs, seconds wrap over 60 incs
    pause1();
    mode1();
    incs(50);
    chk("min_59", dig, 16'h5959);
    incs(1);
    chk("min_wrap", dig, 16'h0059);
    incs(10);
    chk("min_61", dig, 16'h1059);
    chk("smin_blink", {10'd0, flg}, {10'd0, F_SMIN});
    mode1();
    chk("ssec_blink", {10'd0, flg}, {10'd0, F_SSEC});
    incs(1);
    chk("sec_wrap", dig, 16'h1000);
    incs(59);
    chk("sec_60", dig, 16'h1059);
    mode1();
    chk("back_pause", {10'd0, flg}, {10'd0, F_PAUSE});

    // 00:10 -> 00:09
    mode1(); incs(50); mode1(); incs(11); mode1();
    chk("set_0010", dig, 16'h0010);
    pause1();
    ticks(1);
    chk("0010_dec", dig, 16'h0009);

    // pause beats tick; mode beats pause
    ticks(4);
    chk("at_0005", dig, 16'h0005);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    chk("tick_pause_dig", dig, 16'h0005);
    chk("tick_pause_flg", {10'd0, flg}, {10'd0, F_PAUSE});
    step(1'b0, 1'b1, 1'b1, 1'b0);
    chk("mode_pause", {10'd0, flg}, {10'd0, F_SMIN});
    mode1(); mode1();

    // Expire, reload by pause, then pause at 00:00 is ignored
    pause1(); ticks(5);
    chk("exp2", {10'd0, flg}, {10'd0, F_EXP});
    pause1();
    chk("reload_dig", dig, 16'h0100);
    chk("reload_flg", {10'd0, flg}, {10'd0, F_PAUSE});
    mode1(); incs(59); mode1(); mode1();
    chk("zero_set", dig, 16'h0000);
    pause1();
    chk("zero_pause", {10'd0, flg}, {10'd0, F_PAUSE});

    // Expired behaviour with ticks
    mode1(); mode1(); incs(2); mode1(); pause1(); ticks(2);
    chk("exp3", {10'd0, flg}, {10'd0, F_EXP});
`ifdef TIMER_CTRL_AUTORELOAD_EN
    ticks(2);
    chk("auto_wait", {10'd0, flg}, {10'd0, F_EXP});
    ticks(1);
    chk("auto_flg", {10'd0, flg}, {10'd0, F_RUN});
    chk("auto_dig", dig, 16'h0100);
`else
    ticks(20);
    chk("no_auto_flg", {10'd0, flg}, {10'd0, F_EXP});
    chk("no_auto_dig", dig, 16'h0000);
`endif

    // Asynchronous reset while running at 00:30
    pause1();
    mode1(); incs(59); mode1(); incs(30); mode1(); pause1();
    chk("run_0030", dig, 16'h0030);
    chk("run_0030_flg", {10'd0, flg}, {10'd0, F_RUN});
    #2 rst = 1'b1;
    #1;
    chk("async_dig", dig, 16'h0100);
    chk("async_flg", {10'd0, flg}, {10'd0, F_PAUSE});
    #1 rst = 1'b0;
    @(posedge clk); #1;
    chk("post_rst", {10'd0, flg}, {10'd0, F_PAUSE});
    pause1();
    chk("post_rst_run", {10'd0, flg}, {10'd0, F_RUN});

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end
endmodule
